// File: rtl/memory_access.sv
// EX/MEM pipeline register and data-memory access controller: holds the
// execute-stage results, performs one dcache transaction per memory op and stalls until dhit.
module memory_access #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              flush,
  input  logic              ex_dREN,
  input  logic              ex_dWEN,
  input  logic [1:0]        ex_regSel,
  input  logic [WORD_W-1:0] ex_nPC,
  input  logic [WORD_W-1:0] ex_ALUOut,
  input  logic [WORD_W-1:0] ex_lui,
  input  logic [WORD_W-1:0] ex_store,
  input  logic              ex_regWr,
  input  logic [REG_W-1:0]  ex_regDst,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic              dREN,
  output logic              dWEN,
  output logic [1:0]        regSel,
  output logic [WORD_W-1:0] nPC,
  output logic [WORD_W-1:0] ALUOut,
  output logic [WORD_W-1:0] lui,
  output logic              regWr,
  output logic [REG_W-1:0]  regDst,
  output logic [WORD_W-1:0] dmemload,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state, state_nxt;
  logic              pending_flush, pending_flush_nxt;
  logic              advance;
  logic              latch_p0;
  logic              bubble_p0;
  logic              capture_p0;
  logic [WORD_W-1:0] store_p1;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign mem_stall = (state == ACCESS);
  assign advance   = ihit & ~mem_stall;

  // Next state and per-cycle register actions; flush outranks advance outside ACCESS
  always_comb begin
    state_nxt         = state;
    pending_flush_nxt = pending_flush;
    latch_p0          = 1'b0;
    bubble_p0         = 1'b0;
    capture_p0        = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (flush) begin
          bubble_p0 = 1'b1;
          state_nxt = IDLE;
        end else if (advance) begin
          latch_p0  = 1'b1;
          state_nxt = (ex_dREN | ex_dWEN) ? ACCESS : IDLE;
        end
      end
      ACCESS: begin
        if (flush) pending_flush_nxt = 1'b1;
        if (dhit) begin
          if (pending_flush | flush) begin
            bubble_p0         = 1'b1;
            pending_flush_nxt = 1'b0;
            state_nxt         = IDLE;
          end else begin
            capture_p0 = dREN;
            state_nxt  = DONE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      pending_flush <= 1'b0;
      stall_cnt     <= 16'd0;
    end else begin
      state         <= state_nxt;
      pending_flush <= pending_flush_nxt;
      if (state == ACCESS) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  // EX -> MEM boundary: held results, cleared on reset or bubble
  always_ff @(posedge CLK) begin
    if (RST || bubble_p0) begin
      dREN     <= 1'b0;
      dWEN     <= 1'b0;
      regSel   <= 2'd0;
      nPC      <= '0;
      ALUOut   <= '0;
      lui      <= '0;
      store_p1 <= '0;
      regWr    <= 1'b0;
      regDst   <= '0;
      dmemload <= '0;
    end else if (latch_p0) begin
      dREN     <= ex_dREN;
      dWEN     <= ex_dWEN;
      regSel   <= ex_regSel;
      nPC      <= ex_nPC;
      ALUOut   <= ex_ALUOut;
      lui      <= ex_lui;
      store_p1 <= ex_store;
      regWr    <= ex_regWr;
      regDst   <= ex_regDst;
      dmemload <= '0;
    end else if (capture_p0) begin
      dmemload <= dload;
    end
  end

  assign dmemREN   = mem_stall & dREN;
  assign dmemWEN   = mem_stall & dWEN;
  assign dmemaddr  = ALUOut;
  assign dmemstore = store_p1;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: dcache requests and load data are checked
// by monitors against scoreboard queues filled by the stimulus.
module tb_memory_access;

  logic        CLK, RST, ihit, flush;
  logic        ex_dREN, ex_dWEN, ex_regWr, dhit;
  logic [1:0]  ex_regSel;
  logic [31:0] ex_nPC, ex_ALUOut, ex_lui, ex_store, dload;
  logic [4:0]  ex_regDst;
  logic        dmemREN, dmemWEN, mem_stall, dREN, dWEN, regWr;
  logic [31:0] dmemaddr, dmemstore, nPC, ALUOut, lui, dmemload;
  logic [1:0]  regSel;
  logic [4:0]  regDst;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int req_cycles = 0;
  int req_mark;
  logic [65:0] req_q[$];
  logic [31:0] ld_q[$];
  logic prev_req   = 1'b0;
  logic ld_pending = 1'b0;

  memory_access #(.WORD_W(32), .REG_W(5)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .flush(flush),
    .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN), .ex_regSel(ex_regSel), .ex_nPC(ex_nPC),
    .ex_ALUOut(ex_ALUOut), .ex_lui(ex_lui), .ex_store(ex_store), .ex_regWr(ex_regWr),
    .ex_regDst(ex_regDst), .dhit(dhit), .dload(dload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .dREN(dREN), .dWEN(dWEN), .regSel(regSel), .nPC(nPC),
    .ALUOut(ALUOut), .lui(lui), .regWr(regWr), .regDst(regDst), .dmemload(dmemload),
    .stall_cnt(stall_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_ex(input logic ren, input logic wen, input logic [1:0] sel,
                        input logic [31:0] addr, input logic [31:0] st, input logic wr,
                        input logic [4:0] dst);
    ex_dREN = ren; ex_dWEN = wen; ex_regSel = sel; ex_ALUOut = addr; ex_store = st;
    ex_regWr = wr; ex_regDst = dst; ex_nPC = addr + 32'd4; ex_lui = {addr[15:0], 16'h0};
    if (ren | wen) req_q.push_back({ren, wen, addr, st});
  endtask

  task automatic issue(input logic ren, input logic wen, input logic [1:0] sel,
                       input logic [31:0] addr, input logic [31:0] st, input logic wr,
                       input logic [4:0] dst);
    set_ex(ren, wen, sel, addr, st, wr, dst);
    ihit = 1'b1;
    tick();
    ihit = 1'b0;
  endtask

  // Request monitor: each new request must match the next queued transaction
  always @(negedge CLK) begin
    logic req_now;
    logic [65:0] exp_req;
    req_now = dmemREN | dmemWEN;
    if (req_now) req_cycles++;
    if (req_now && !prev_req) begin
      if (req_q.size() == 0) begin
        check("unexpected_request", {dmemREN, dmemWEN, dmemaddr, dmemstore}, 66'd0);
      end else begin
        exp_req = req_q.pop_front();
        check("dcache_request", {dmemREN, dmemWEN, dmemaddr, dmemstore}, exp_req);
      end
    end
    prev_req = req_now;
  end

  // Load-data monitor: dmemload is checked the cycle after a read dhit
  always @(negedge CLK) begin
    logic [31:0] exp_ld;
    if (ld_pending) begin
      if (ld_q.size() == 0) begin
        check("unexpected_load", 66'(dmemload), 66'd0);
      end else begin
        exp_ld = ld_q.pop_front();
        check("dmemload", 66'(dmemload), 66'(exp_ld));
      end
    end
    ld_pending = dhit & dmemREN & ~RST;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; ihit = 1'b0; flush = 1'b0; dhit = 1'b0; dload = '0;
    set_ex(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 5'd0);
    tick(); tick();
    check("rst_ALUOut", 66'(ALUOut), 66'd0);
    check("rst_regSel", 66'(regSel), 66'd0);
    check("rst_mem_stall", 66'(mem_stall), 66'd0);
    check("rst_dmemREN", 66'(dmemREN), 66'd0);
    check("rst_stall_cnt", 66'(stall_cnt), 66'd0);
    RST = 1'b0;

    // ALU op passes through with no request
    issue(1'b0, 1'b0, 2'd0, 32'h10, 32'h0, 1'b1, 5'd3);
    check("alu_ALUOut", 66'(ALUOut), 66'h10);
    check("alu_regWr", 66'(regWr), 66'd1);
    check("alu_dmemREN", 66'(dmemREN), 66'd0);
    check("alu_mem_stall", 66'(mem_stall), 66'd0);

    // Load 0x40 with dhit in the third ACCESS cycle
    req_mark = req_cycles;
    issue(1'b1, 1'b0, 2'd1, 32'h40, 32'h0, 1'b1, 5'd5);
    check("ld_stall_c1", 66'(mem_stall), 66'd1);
    check("ld_dmemREN_c1", 66'(dmemREN), 66'd1);
    tick();
    check("ld_stall_c2", 66'(mem_stall), 66'd1);
    tick();
    dhit = 1'b1; dload = 32'hDEADBEEF; ld_q.push_back(32'hDEADBEEF);
    tick();
    dhit = 1'b0; dload = '0;
    check("ld_dmemload", 66'(dmemload), 66'hDEADBEEF);
    check("ld_regSel", 66'(regSel), 66'd1);
    check("ld_stall_cnt", 66'(stall_cnt), 66'd3);
    check("ld_mem_stall_done", 66'(mem_stall), 66'd0);
    #5;
    check("ld_req_cycles", 66'(req_cycles - req_mark), 66'd3);
    #1;

    // Store with same-cycle dhit, then ihit low for four cycles in DONE
    req_mark = req_cycles;
    issue(1'b0, 1'b1, 2'd0, 32'h80, 32'h1234, 1'b0, 5'd0);
    dhit = 1'b1;
    tick();
    dhit = 1'b0;
    repeat (4) tick();
    check("st_req_cycles", 66'(req_cycles - req_mark), 66'd1);
    check("st_dWEN_held", 66'(dWEN), 66'd1);
    check("st_ALUOut_held", 66'(ALUOut), 66'h80);
    check("st_mem_stall", 66'(mem_stall), 66'd0);
    check("st_stall_cnt", 66'(stall_cnt), 66'd4);

    // Flush during a load: access completes, stage becomes a bubble
    issue(1'b1, 1'b0, 2'd1, 32'h44, 32'h0, 1'b1, 5'd7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_stall_deferred", 66'(mem_stall), 66'd1);
    tick();
    dhit = 1'b1; dload = 32'hCAFEF00D; ld_q.push_back(32'h0);
    tick();
    dhit = 1'b0; dload = '0;
    check("fl_regWr", 66'(regWr), 66'd0);
    check("fl_dREN", 66'(dREN), 66'd0);
    check("fl_ALUOut", 66'(ALUOut), 66'd0);
    check("fl_mem_stall", 66'(mem_stall), 66'd0);
    check("fl_stall_cnt", 66'(stall_cnt), 66'd7);

    // Back-to-back loads, dhit same cycle, ihit held high
    req_mark = req_cycles;
    set_ex(1'b1, 1'b0, 2'd1, 32'h100, 32'h0, 1'b1, 5'd10);
    ihit = 1'b1;
    tick();
    dhit = 1'b1; dload = 32'h11111111; ld_q.push_back(32'h11111111);
    set_ex(1'b1, 1'b0, 2'd1, 32'h104, 32'h0, 1'b1, 5'd11);
    tick();
    dhit = 1'b0; dload = '0;
    check("b2b_regDst_a", 66'(regDst), 66'd10);
    tick();
    check("b2b_cleared", 66'(dmemload), 66'd0);
    dhit = 1'b1; dload = 32'h22222222; ld_q.push_back(32'h22222222);
    set_ex(1'b0, 1'b0, 2'd0, 32'h55, 32'h0, 1'b1, 5'd9);
    tick();
    dhit = 1'b0; dload = '0;
    check("b2b_regDst_b", 66'(regDst), 66'd11);
    tick();
    ihit = 1'b0;
    check("b2b_alu_ALUOut", 66'(ALUOut), 66'h55);
    check("b2b_req_cycles", 66'(req_cycles - req_mark), 66'd2);
    check("b2b_stall_cnt", 66'(stall_cnt), 66'd9);

    // Flush in IDLE beats advance
    set_ex(1'b0, 1'b0, 2'd3, 32'h66, 32'h0, 1'b1, 5'd12);
    flush = 1'b1; ihit = 1'b1;
    tick();
    flush = 1'b0; ihit = 1'b0;
    check("idle_fl_ALUOut", 66'(ALUOut), 66'd0);
    check("idle_fl_regWr", 66'(regWr), 66'd0);
    check("idle_fl_regSel", 66'(regSel), 66'd0);

    // Reset mid-ACCESS, together with flush
    issue(1'b1, 1'b0, 2'd1, 32'h200, 32'h0, 1'b1, 5'd13);
    tick();
    RST = 1'b1; flush = 1'b1;
    tick();
    check("rstm_dmemREN", 66'(dmemREN), 66'd0);
    check("rstm_mem_stall", 66'(mem_stall), 66'd0);
    check("rstm_ALUOut", 66'(ALUOut), 66'd0);
    check("rstm_regWr", 66'(regWr), 66'd0);
    check("rstm_stall_cnt", 66'(stall_cnt), 66'd0);
    RST = 1'b0; flush = 1'b0;
    tick();
    check("rstm_idle_after", 66'(dmemREN | dmemWEN | mem_stall), 66'd0);

    tick();
    check("req_queue_drained", 66'(req_q.size()), 66'd0);
    check("ld_queue_drained", 66'(ld_q.size()), 66'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
